bp_me_lite_to_burst: RTL and testbench
======================================

# bp_me_lite_to_burst

Converts one BedRock Lite message (header plus full-width data) into a BedRock Burst stream: one header beat on a header channel and zero or more narrow data beats on a separate data channel. It sits directly upstream of the burst-to-lite converter, or of any burst client, on the memory/IO path. One message is held at a time, and the block serialises its data locally.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: processor configuration; supplies `paddr_width_p`, `lce_id_width_p`, `lce_assoc_p`.
- `in_data_width_p`, default "inv": Lite data width (wide side).
- `out_data_width_p`, default "inv": Burst data beat width (narrow side).
- `payload_width_p`, default "inv": BedRock header payload width.
- `payload_mask_p`, default 0: bitmask of `msg_type` values that carry data, i.e. `(1 << e_type_a) | (1 << e_type_b)`.
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `in_msg_i`  in  `in_msg_width_lp`  Lite message (header, data).
- `in_msg_v_i`  in  1  Lite valid.
- `in_msg_ready_and_o`  out  1  Lite ready (ready-valid-and).
- `out_msg_header_o`  out  `out_msg_header_width_lp`  Burst header.
- `out_msg_header_v_o`  out  1  header valid.
- `out_msg_header_ready_and_i`  in  1  header ready.
- `out_msg_data_o`  out  `out_data_width_p`  Burst data beat.
- `out_msg_data_v_o`  out  1  data valid.
- `out_msg_data_ready_and_i`  in  1  data ready.

## Operation
- Derived values:
  - `burst_words_lp = in_data_width_p/out_data_width_p`.
  - Beat counter width is `BSG_SAFE_CLOG2(burst_words_lp)`.
  - Beat count uses `num_beats = has_data ? BSG_MAX(1, (1<<size)/out_data_bytes) : 0`, where `has_data = payload_mask_p[msg_type]`.
- States:
  - e_ready: `in_msg_ready_and_o = 1`.
  - e_busy.
- e_ready -> e_busy on `in_msg_v_i & in_msg_ready_and_o`. On this transition the block:
  - registers the header and the full data word;
  - sets `hdr_pending = 1`;
  - loads `beats_left = num_beats`;
  - clears the beat index.
- In e_busy:
  - `out_msg_header_v_o = hdr_pending`. The header handshake clears `hdr_pending`.
  - `out_msg_data_v_o = (beats_left != 0)`.
  - `out_msg_data_o` = registered data `[idx*out_data_width_p +: out_data_width_p]`.
  - The data handshake increments `idx` and decrements `beats_left`.
- The header and data channels are independent. Data beats may be sent before, with, or after the header. A downstream consumer pairs them itself.
- e_busy -> e_ready in the cycle after `hdr_pending == 0` and `beats_left == 0`, counting the effect of handshakes in the current cycle.
- There is no same-cycle accept-on-drain. Ready is registered state only, so there is no combinational path from `*_ready_and_i` to `in_msg_ready_and_o`.
- Messages with no data: only the header is emitted, and `out_msg_data_v_o` stays 0.
- Messages smaller than one beat: exactly 1 beat, taken from the low `out_data_width_p` bits.
- The header is passed through unmodified, including `size`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = e_ready; `hdr_pending = 0`, `beats_left = 0`, `idx = 0`.
  - `out_msg_header_v_o = 0`, `out_msg_data_v_o = 0`.
  - `in_msg_ready_and_o = 0` while `reset_i` is high, and 1 from the first cycle after deassertion.
  - Data and header registers are don't-care.
- Reset mid-message: the message in flight is dropped. No further beats are emitted.
- Latency: header valid and first data beat valid both appear 1 cycle after the Lite accept.
- Throughput with both channels always ready: N beats take N cycles in e_busy, plus 1 idle cycle back in e_ready before the next accept. A data-less message takes 1 busy cycle plus 1 ready cycle.
- Valid outputs and data are held stable until their handshake completes. Valid never drops without a handshake.

## Structure
- BedRock structs and widths come from the `declare_bp_bedrock_if` and `declare_bp_bedrock_if_widths` macros in `bp_me_pkg`.
- The state enum is local to this block.
- Natural sub-module: `bsg_parallel_in_serial_out_dynamic`, for the data register, index and length.
- Header holding uses a `bsg_dff_en` plus the `hdr_pending` flag.
- Elaboration assertions:
  - `in_data_width_p > out_data_width_p`;
  - the width is an exact multiple.

## Test plan
Configuration: `in_data_width_p = 512`, `out_data_width_p = 64`, `payload_mask_p` = uncached write | write.
- 64 B write, data `0x00..3F`, both channels ready -> header at cycle 1; beats 0..7 equal bytes `[8k+7:8k]` on cycles 1..8; `in_msg_ready_and_o` is 1 at cycle 10.
- 8 B uncached write, data `0xDEADBEEF_CAFEF00D` -> exactly 1 beat of `0xDEADBEEF_CAFEF00D`, then ready.
- 1 B write -> exactly 1 beat. A read of 64 B -> header only, `out_msg_data_v_o` never asserts.
- Header ready held low for 5 cycles during a 64 B write -> all 8 beats are emitted, the header is held stable, and the block returns to e_ready only after the header handshake.
- Random 50% backpressure on both channels, 200 messages -> scoreboard matches every header and beat, order is preserved, and no beat is duplicated or dropped.
- `reset_i` asserted after 3 of 8 beats -> both valid outputs drop immediately. After release, a new 8 B write is emitted correctly.

Source files
------------

// File: rtl/bp_me_lite_to_burst_pkg.sv
// Shared types for the Lite-to-Burst converter: a compact BedRock-style header
// and the beat-count helper used to size the data burst.
package bp_me_lite_to_burst_pkg;

  localparam int paddr_width_gp   = 40;
  localparam int payload_width_gp = 24;

  typedef enum logic [3:0] {
    e_mem_rd    = 4'd0,
    e_mem_wr    = 4'd1,
    e_mem_uc_rd = 4'd2,
    e_mem_uc_wr = 4'd3,
    e_mem_amo   = 4'd4
  } msg_type_e;

  // size encodes log2(bytes) of the transfer
  typedef enum logic [2:0] {
    e_size_1   = 3'd0,
    e_size_2   = 3'd1,
    e_size_4   = 3'd2,
    e_size_8   = 3'd3,
    e_size_16  = 3'd4,
    e_size_32  = 3'd5,
    e_size_64  = 3'd6,
    e_size_128 = 3'd7
  } size_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    logic [2:0]                  size;
    logic [paddr_width_gp-1:0]   addr;
    logic [3:0]                  subop;
    logic [3:0]                  msg_type;
  } header_s;

  localparam int header_width_gp = $bits(header_s);

  // Sub-beat messages still need one beat; oversize requests are capped to the buffer.
  function automatic int unsigned burst_beats(input logic [2:0] size,
                                              input int unsigned out_bytes,
                                              input int unsigned max_beats);
    int unsigned n;
    n = (32'd1 << size) / out_bytes;
    if (n == 0) n = 1;
    if (n > max_beats) n = max_beats;
    return n;
  endfunction

endpackage

// File: rtl/bp_me_lite_to_burst_piso.sv
// Parallel-in serial-out buffer with a per-load beat count: holds one wide
// word and hands it out low slice first.
module bp_me_lite_to_burst_piso
  import bp_me_lite_to_burst_pkg::*;
#(
  parameter int width_p = 64,
  parameter int els_p   = 8,
  localparam int idx_width_lp = (els_p <= 1) ? 1 : $clog2(els_p),
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       load_i,
  input  logic [width_p*els_p-1:0]   data_i,
  input  logic [cnt_width_lp-1:0]    len_i,
  output logic [width_p-1:0]         data_o,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic                       drained_o
);

  logic [els_p-1:0][width_p-1:0] data_q;
  logic [idx_width_lp-1:0]       idx_q, idx_d;
  logic [cnt_width_lp-1:0]       beats_left_q, beats_left_d;

  always_comb begin
    idx_d        = idx_q;
    beats_left_d = beats_left_q;
    if (load_i) begin
      idx_d        = '0;
      beats_left_d = len_i;
    end else if (yumi_i & v_o) begin
      idx_d        = idx_q + idx_width_lp'(1);
      beats_left_d = beats_left_q - cnt_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q        <= '0;
      beats_left_q <= '0;
    end else begin
      idx_q        <= idx_d;
      beats_left_q <= beats_left_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) data_q <= data_i;
  end

  assign data_o    = data_q[idx_q];
  assign v_o       = (beats_left_q != '0);
  // True when no beat will remain after this cycle's handshake.
  assign drained_o = (beats_left_q == '0)
                   | ((beats_left_q == cnt_width_lp'(1)) & yumi_i);

endmodule

// File: rtl/bp_me_lite_to_burst.sv
// Lite-to-Burst converter: accepts one header+wide-data message and emits the
// header and the narrow data beats on independent valid/ready channels.
module bp_me_lite_to_burst
  import bp_me_lite_to_burst_pkg::*;
#(
  parameter int          in_data_width_p  = 512,
  parameter int          out_data_width_p = 64,
  parameter int          payload_width_p  = payload_width_gp,
  parameter logic [15:0] payload_mask_p   = '0,
  localparam int in_msg_width_lp         = header_width_gp + in_data_width_p,
  localparam int out_msg_header_width_lp = header_width_gp
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [in_msg_width_lp-1:0]         in_msg_i,
  input  logic                               in_msg_v_i,
  output logic                               in_msg_ready_and_o,
  output logic [out_msg_header_width_lp-1:0] out_msg_header_o,
  output logic                               out_msg_header_v_o,
  input  logic                               out_msg_header_ready_and_i,
  output logic [out_data_width_p-1:0]        out_msg_data_o,
  output logic                               out_msg_data_v_o,
  input  logic                               out_msg_data_ready_and_i,
  output logic [0:0]                         state_o
);

  // Handshakes on every channel: a transfer happens in a cycle where valid and
  // ready are both high; valid and its payload stay put until that cycle.

  localparam int burst_words_lp    = in_data_width_p / out_data_width_p;
  localparam int cnt_width_lp      = $clog2(burst_words_lp + 1);
  localparam int out_data_bytes_lp = out_data_width_p / 8;

  localparam logic [0:0] e_ready = 1'b0;
  localparam logic [0:0] e_busy  = 1'b1;

  if (in_data_width_p <= out_data_width_p) begin : g_bad_ratio
    $error("in_data_width_p must exceed out_data_width_p");
  end
  if (in_data_width_p % out_data_width_p != 0) begin : g_bad_multiple
    $error("in_data_width_p must be a multiple of out_data_width_p");
  end
  if (payload_width_p != payload_width_gp) begin : g_bad_payload
    $error("payload_width_p must match the package header payload width");
  end

  header_s                    in_header;
  logic [in_data_width_p-1:0] in_data;
  header_s                    header_q;
  logic [0:0]                 state_q, state_d;
  logic                       hdr_pending_q, hdr_pending_d;
  logic                       accept;
  logic                       has_data;
  logic [cnt_width_lp-1:0]    num_beats;
  logic                       data_yumi;
  logic                       data_drained;

  // Header occupies the low bits of the Lite message, data the high bits.
  assign in_header = in_msg_i[header_width_gp-1:0];
  assign in_data   = in_msg_i[in_msg_width_lp-1:header_width_gp];

  assign in_msg_ready_and_o = (state_q == e_ready) & ~reset_i;
  assign accept             = in_msg_v_i & in_msg_ready_and_o;

  assign has_data  = payload_mask_p[in_header.msg_type];
  assign num_beats = has_data
    ? cnt_width_lp'(burst_beats(in_header.size, out_data_bytes_lp, burst_words_lp))
    : '0;

  always_comb begin
    state_d       = state_q;
    hdr_pending_d = hdr_pending_q;
    if (hdr_pending_q & out_msg_header_ready_and_i) hdr_pending_d = 1'b0;
    case (state_q)
      e_ready: begin
        if (accept) begin
          state_d       = e_busy;
          hdr_pending_d = 1'b1;
        end
      end
      e_busy: begin
        if (!hdr_pending_d && data_drained) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= e_ready;
      hdr_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_pending_q <= hdr_pending_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) header_q <= in_header;
  end

  assign out_msg_header_o   = header_q;
  assign out_msg_header_v_o = hdr_pending_q;
  assign data_yumi          = out_msg_data_v_o & out_msg_data_ready_and_i;
  assign state_o            = state_q;

  bp_me_lite_to_burst_piso #(
    .width_p (out_data_width_p),
    .els_p   (burst_words_lp)
  ) u_piso (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (accept),
    .data_i    (in_data),
    .len_i     (num_beats),
    .data_o    (out_msg_data_o),
    .v_o       (out_msg_data_v_o),
    .yumi_i    (data_yumi),
    .drained_o (data_drained)
  );

endmodule

// File: tb/tb_bp_me_lite_to_burst.sv
// Directed and backpressured bench for bp_me_lite_to_burst (512-bit Lite, 64-bit beats).
module tb_bp_me_lite_to_burst;
  import bp_me_lite_to_burst_pkg::*;

  localparam int DW  = 512;
  localparam int BW  = 64;
  localparam int HW  = header_width_gp;
  localparam int MW  = HW + DW;

  logic          clk;
  logic          reset_i;
  logic [MW-1:0] in_msg;
  logic          in_v;
  logic          in_rdy;
  logic [HW-1:0] hdr_o;
  logic          hdr_v;
  logic          hdr_rdy;
  logic [BW-1:0] data_o;
  logic          data_v;
  logic          data_rdy;
  logic [0:0]    state;

  int chk_cnt = 0;
  int err_cnt = 0;
  int beats_seen = 0;
  int data_v_seen = 0;
  logic rand_mode = 1'b0;

  logic [HW-1:0] exp_hdr_q[$];
  logic [BW-1:0] exp_q[$];

  bp_me_lite_to_burst #(
    .in_data_width_p  (DW),
    .out_data_width_p (BW),
    .payload_width_p  (payload_width_gp),
    .payload_mask_p   (16'h000A)
  ) dut (
    .clk_i                      (clk),
    .reset_i                    (reset_i),
    .in_msg_i                   (in_msg),
    .in_msg_v_i                 (in_v),
    .in_msg_ready_and_o         (in_rdy),
    .out_msg_header_o           (hdr_o),
    .out_msg_header_v_o         (hdr_v),
    .out_msg_header_ready_and_i (hdr_rdy),
    .out_msg_data_o             (data_o),
    .out_msg_data_v_o           (data_v),
    .out_msg_data_ready_and_i   (data_rdy),
    .state_o                    (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic header_s mk_hdr(input logic [3:0] t, input logic [2:0] sz,
                                     input logic [39:0] a, input logic [23:0] p);
    header_s h;
    h.msg_type = t;
    h.subop    = 4'h0;
    h.addr     = a;
    h.size     = sz;
    h.payload  = p;
    return h;
  endfunction

  // Driver: queue the expected header and beats, then hold valid until accepted.
  task automatic send_msg(input header_s h, input logic [DW-1:0] d);
    int n;
    bit done;
    n = 0;
    if (h.msg_type == e_mem_wr || h.msg_type == e_mem_uc_wr) begin
      n = (1 << h.size) / 8;
      if (n == 0) n = 1;
      if (n > 8) n = 8;
    end
    exp_hdr_q.push_back(h);
    for (int k = 0; k < n; k++) exp_q.push_back(d[k*BW +: BW]);
    @(posedge clk); #1;
    in_msg = {d, h};
    in_v   = 1'b1;
    done   = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_rdy) done = 1'b1;
    end
    if (!done) check("accept_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    in_v = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (in_rdy && exp_hdr_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 128'(0), 128'(1));
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      hdr_rdy  = 1'($urandom_range(0, 1));
      data_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: pops expectations in order and checks hold-while-stalled.
  logic          h_hold, d_hold;
  logic [HW-1:0] h_prev;
  logic [BW-1:0] d_prev;
  initial begin h_hold = 1'b0; d_hold = 1'b0; end

  always @(negedge clk) begin
    if (reset_i) begin
      h_hold = 1'b0;
      d_hold = 1'b0;
    end else begin
      if (h_hold) begin
        check("hdr_v_hold", 128'(hdr_v), 128'(1));
        check("hdr_hold", 128'(hdr_o), 128'(h_prev));
      end
      if (d_hold) begin
        check("data_v_hold", 128'(data_v), 128'(1));
        check("data_hold", 128'(data_o), 128'(d_prev));
      end
      if (hdr_v && hdr_rdy) begin
        if (exp_hdr_q.size() == 0) check("hdr_unexpected", 128'(1), 128'(0));
        else check("hdr", 128'(hdr_o), 128'(exp_hdr_q.pop_front()));
      end
      if (data_v) data_v_seen++;
      if (data_v && data_rdy) begin
        beats_seen++;
        if (exp_q.size() == 0) check("beat_unexpected", 128'(1), 128'(0));
        else check("beat", 128'(data_o), 128'(exp_q.pop_front()));
      end
      h_hold = hdr_v && !hdr_rdy;
      h_prev = hdr_o;
      d_hold = data_v && !data_rdy;
      d_prev = data_o;
    end
  end

  initial begin
    header_s         h;
    logic [DW-1:0]   d;
    logic [3:0]      types [4];
    types[0] = e_mem_rd; types[1] = e_mem_wr; types[2] = e_mem_uc_rd; types[3] = e_mem_uc_wr;

    reset_i  = 1'b1;
    in_v     = 1'b0;
    in_msg   = '0;
    hdr_rdy  = 1'b1;
    data_rdy = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_rdy", 128'(in_rdy), 128'(0));
    check("rst_hdr_v", 128'(hdr_v), 128'(0));
    check("rst_data_v", 128'(data_v), 128'(0));
    check("rst_state", 128'(state), 128'(0));
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 128'(in_rdy), 128'(1));

    // 64 B write, bytes 0x00..0x3F, cycle-accurate timing
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i);
    h = mk_hdr(e_mem_wr, e_size_64, 40'h00_1000_0040, 24'h00_0011);
    exp_hdr_q.push_back(h);
    for (int k = 0; k < 8; k++) exp_q.push_back(64'h0706050403020100 + 64'(k) * 64'h0808080808080808);
    @(posedge clk); #1;
    in_msg = {d, h};
    in_v   = 1'b1;
    @(negedge clk);
    check("t1_rdy_c0", 128'(in_rdy), 128'(1));
    @(posedge clk); #1;
    in_v = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t1_data_v", 128'(data_v), 128'(1));
      check("t1_hdr_v", 128'(hdr_v), 128'(k == 1));
      check("t1_rdy_busy", 128'(in_rdy), 128'(0));
    end
    check("t1_state_busy", 128'(state), 128'(1));
    @(negedge clk);
    check("t1_data_v_c9", 128'(data_v), 128'(0));
    check("t1_hdr_v_c9", 128'(hdr_v), 128'(0));
    @(negedge clk);
    check("t1_rdy_c10", 128'(in_rdy), 128'(1));
    check("t1_drain", 128'(exp_q.size()), 128'(0));

    // 8 B uncached write: one beat from the low slice only
    d = {16{32'hA5A5_5A5A}};
    d[63:0] = 64'hDEADBEEF_CAFEF00D;
    beats_seen = 0;
    send_msg(mk_hdr(e_mem_uc_wr, e_size_8, 40'h00_0000_0008, 24'h00_0022), d);
    wait_idle();
    check("t2_beats", 128'(beats_seen), 128'(1));

    // 1 B write: still one beat
    d[63:0] = 64'h1122334455667788;
    beats_seen = 0;
    send_msg(mk_hdr(e_mem_wr, e_size_1, 40'h00_0000_0003, 24'h00_0033), d);
    wait_idle();
    check("t3_beats", 128'(beats_seen), 128'(1));

    // 64 B read: header only
    data_v_seen = 0;
    send_msg(mk_hdr(e_mem_rd, e_size_64, 40'h00_0000_0100, 24'h00_0044), d);
    wait_idle();
    check("t3_read_no_data_v", 128'(data_v_seen), 128'(0));

    // Header stalled while all 8 beats drain
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(8'hC0 + i);
    h = mk_hdr(e_mem_wr, e_size_64, 40'h00_2000_0000, 24'h00_0055);
    hdr_rdy = 1'b0;
    beats_seen = 0;
    send_msg(h, d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hdr_v", 128'(hdr_v), 128'(1));
      check("t4_hdr_stable", 128'(hdr_o), 128'(h));
      check("t4_rdy_low", 128'(in_rdy), 128'(0));
    end
    check("t4_beats", 128'(beats_seen), 128'(8));
    @(posedge clk); #1;
    hdr_rdy = 1'b1;
    @(negedge clk);
    check("t4_hdr_hs", 128'(hdr_v), 128'(1));
    @(negedge clk);
    check("t4_hdr_v_done", 128'(hdr_v), 128'(0));
    check("t4_rdy_back", 128'(in_rdy), 128'(1));

    // Random backpressure, 200 messages
    rand_mode = 1'b1;
    for (int m = 0; m < 200; m++) begin
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      h = mk_hdr(types[$urandom_range(0, 3)], 3'($urandom_range(0, 6)),
                 40'($urandom), 24'($urandom));
      send_msg(h, d);
      wait_idle();
    end
    rand_mode = 1'b0;
    @(posedge clk); #1;
    hdr_rdy  = 1'b1;
    data_rdy = 1'b1;
    check("t5_hdr_drain", 128'(exp_hdr_q.size()), 128'(0));
    check("t5_beat_drain", 128'(exp_q.size()), 128'(0));

    // Reset after 3 of 8 beats
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(8'h40 + i);
    beats_seen = 0;
    send_msg(mk_hdr(e_mem_wr, e_size_64, 40'h00_3000_0000, 24'h00_0066), d);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_i = 1'b1;
    #1;
    check("t6_beats_before", 128'(beats_seen), 128'(3));
    check("t6_data_v_drop", 128'(data_v), 128'(0));
    check("t6_hdr_v_drop", 128'(hdr_v), 128'(0));
    check("t6_rdy_in_rst", 128'(in_rdy), 128'(0));
    exp_hdr_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    data_v_seen = 0;
    @(negedge clk);
    check("t6_no_beats_after", 128'(data_v_seen), 128'(0));
    d[63:0] = 64'h0123456789ABCDEF;
    beats_seen = 0;
    send_msg(mk_hdr(e_mem_wr, e_size_8, 40'h00_0000_0010, 24'h00_0077), d);
    wait_idle();
    check("t6_new_beats", 128'(beats_seen), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
